stream_mux: RTL

STREAM_MUX -- requirements
Module: stream_mux

---
 rtl/stream_mux.sv | 102 ++++++++++
 1 files changed

// File: rtl/stream_mux.sv
// stream_mux: N-channel valid/ready stream multiplexer with a registered output stage.
// Fixed-select or round-robin arbitration; one word per cycle under continuous flow.
// Optional feature macro: STREAM_MUX_PARITY_EN adds out_parity (even parity of out_data).
module stream_mux #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SW      = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SW-1:0]             sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SW-1:0]             out_chan
`ifdef STREAM_MUX_PARITY_EN
  ,
  output logic                      out_parity
`endif
);

  logic             load;
  logic             accept;
  logic [SW-1:0]    last;
  logic [SW-1:0]    rr_grant;
  logic             rr_ok;
  logic             fix_ok;
  logic [SW-1:0]    grant;
  logic             grant_ok;
  logic [WIDTH-1:0] grant_data;

  // Output register can take a word when empty or draining this cycle.
  assign load = ~out_valid | out_ready;

  // Round-robin search starting one past the last served channel, with wrap.
  always_comb begin
    int unsigned idx;
    rr_grant = last;
    rr_ok    = 1'b0;
    idx      = 0;
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      idx = (32'(last) + i) % CHANNELS;
      if (!rr_ok && in_valid[SW'(idx)]) begin
        rr_grant = SW'(idx);
        rr_ok    = 1'b1;
      end
    end
  end

  // Fixed select; out-of-range sel simply never grants.
  assign fix_ok   = (32'(sel) < CHANNELS) && in_valid[sel];
  assign grant    = mode ? rr_grant : sel;
  assign grant_ok = mode ? rr_ok : fix_ok;
  assign accept   = rst_n & load & grant_ok;

  // Select granted channel's data and produce the one-hot ready.
  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (grant == SW'(k)) begin
        grant_data  = in_data[k*WIDTH +: WIDTH];
        in_ready[k] = accept;
      end
    end
  end

  // Output stage and arbitration pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      last      <= SW'(CHANNELS - 1);
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_chan  <= grant;
      last      <= grant;
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

`ifdef STREAM_MUX_PARITY_EN
  // Parity travels with the word it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
    end else if (accept) begin
      out_parity <= ^grant_data;
    end
  end
`else
  // Parity output not built in this configuration.
`endif

endmodule
